pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_reconfig_ctrl_if.sv | 21 ++
 rtl/pll_reconfig_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_ctrl_if.sv
// APB write port between the reconfiguration controller (master) and the PLL
// register block (slave).
interface pll_reconfig_ctrl_if;
    logic        apb_rst_n;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic [4:0]  apb_addr;
    logic [15:0] apb_wdata;
    logic        apb_ready;

    modport master (
        output apb_rst_n, apb_sel, apb_en, apb_write, apb_addr, apb_wdata,
        input  apb_ready
    );

    modport slave (
        input  apb_rst_n, apb_sel, apb_en, apb_write, apb_addr, apb_wdata,
        output apb_ready
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: holds the PLL in reset, writes NUM_WR
// registers over APB, releases reset and waits for lock, with timeouts.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for cfg_start; watches for loss of lock
// S_PRE_RST   | pll_rst held for RST_HOLD cycles before the first write
// S_SETUP     | APB setup phase for entry idx_q
// S_ACCESS    | APB access phase, waiting for apb_ready (APB_TIMEOUT bound)
// S_RELEASE   | one cycle with pll_rst dropped, lock timer armed
// S_WAIT_LOCK | waiting for synchronized lock (LOCK_TIMEOUT bound)
module pll_reconfig_ctrl #(
    parameter int NUM_WR       = 4,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int APB_TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [5*NUM_WR-1:0]    cfg_addr,
    input  logic [16*NUM_WR-1:0]   cfg_data,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [1:0]             err_code,
    output logic                   pll_rst,
    input  logic                   pll_lock,
    output logic                   locked,
    output logic                   lock_lost,
    pll_reconfig_ctrl_if.master    apb
);

    localparam int T_A   = (LOCK_TIMEOUT > APB_TIMEOUT) ? LOCK_TIMEOUT : APB_TIMEOUT;
    localparam int T_MAX = (T_A > RST_HOLD) ? T_A : RST_HOLD;
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_RST, S_SETUP, S_ACCESS, S_RELEASE, S_WAIT_LOCK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [5*NUM_WR-1:0]  addr_q;
    logic [16*NUM_WR-1:0] data_q;
    logic [1:0]           err_code_q, err_code_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 capture;
    logic                 sync1_q, lock_s, lock_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 apb_rst_n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            err_code_q  <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sync1_q     <= 1'b0;
            lock_s      <= 1'b0;
            lock_d      <= 1'b0;
            lock_lost_q <= 1'b0;
            apb_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_code_q  <= err_code_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sync1_q     <= pll_lock;
            lock_s      <= sync1_q;
            lock_d      <= lock_s;
            lock_lost_q <= lock_lost_d;
            apb_rst_n_q <= 1'b1;
            if (capture) begin
                addr_q <= cfg_addr;
                data_q <= cfg_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    capture    = 1'b1;
                    idx_d      = '0;
                    err_code_d = 2'b00;
                    cnt_d      = CNT_W'(RST_HOLD - 1);
                    state_d    = S_PRE_RST;
                end
            end
            S_PRE_RST: begin
                if (cnt_q == '0) state_d = S_SETUP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_SETUP: begin
                cnt_d   = CNT_W'(APB_TIMEOUT - 1);
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (apb.apb_ready) begin
                    if (int'(idx_q) == NUM_WR - 1) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SETUP;
                    end
                end else if (cnt_q == '0) begin
                    err_code_d = 2'b01;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    err_code_d = 2'b10;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lock loss is only meaningful while idle; during reconfiguration it is expected.
    assign lock_lost_d = (state_q == S_IDLE) && !cfg_start && lock_d && !lock_s;

    logic apb_active;
    assign apb_active = (state_q == S_SETUP) || (state_q == S_ACCESS);

    assign cfg_busy      = (state_q != S_IDLE);
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;
    assign err_code      = err_code_q;
    assign pll_rst       = (state_q == S_PRE_RST) || apb_active;
    assign locked        = lock_s;
    assign lock_lost     = lock_lost_q;
    assign apb.apb_rst_n = apb_rst_n_q;
    assign apb.apb_sel   = apb_active;
    assign apb.apb_en    = (state_q == S_ACCESS);
    assign apb.apb_write = apb_active;
    assign apb.apb_addr  = apb_active ? addr_q[int'(idx_q)*5 +: 5] : 5'd0;
    assign apb.apb_wdata = apb_active ? data_q[int'(idx_q)*16 +: 16] : 16'd0;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: full sequences, APB wait states,
// APB and lock timeouts, start-while-busy, mid-run reset and lock-loss detection.
module tb_pll_reconfig_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [19:0] cfg_addr;
    logic [63:0] cfg_data;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [1:0]  err_code;
    logic        pll_rst, pll_lock, locked, lock_lost;

    pll_reconfig_ctrl_if apb_if ();

    pll_reconfig_ctrl #(
        .NUM_WR(4), .RST_HOLD(16), .LOCK_TIMEOUT(100), .APB_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_code(err_code), .pll_rst(pll_rst),
        .pll_lock(pll_lock), .locked(locked), .lock_lost(lock_lost),
        .apb(apb_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0, err_cnt = 0, ll_cnt = 0, proto_bad = 0;
    int n, d0, e0;

    localparam logic [19:0] ADDR_VEC = {5'h1F, 5'h11, 5'h0A, 5'h03};
    localparam logic [63:0] DATA_VEC = {16'h00FF, 16'h5A5A, 16'hABCD, 16'h1234};
    logic [4:0]  exp_addr [4] = '{5'h03, 5'h0A, 5'h11, 5'h1F};
    logic [15:0] exp_data [4] = '{16'h1234, 16'hABCD, 16'h5A5A, 16'h00FF};

    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_err) err_cnt++;
        if (lock_lost) ll_cnt++;
        if (apb_if.apb_en && !apb_if.apb_sel) proto_bad++;
        if (apb_if.apb_write && !apb_if.apb_sel) proto_bad++;
        if (cfg_done && cfg_err) proto_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    // Called at the SETUP sample point of write w; ACCESS lasts acc cycles.
    task automatic write_pair(input int w, input int acc);
        apb_if.apb_ready = (acc == 1);
        chk($sformatf("w%0d_setup_sel", w), apb_if.apb_sel, 1);
        chk($sformatf("w%0d_setup_en", w), apb_if.apb_en, 0);
        chk($sformatf("w%0d_setup_write", w), apb_if.apb_write, 1);
        chk($sformatf("w%0d_setup_addr", w), apb_if.apb_addr, exp_addr[w]);
        chk($sformatf("w%0d_setup_data", w), apb_if.apb_wdata, exp_data[w]);
        chk($sformatf("w%0d_setup_pllrst", w), pll_rst, 1);
        step();
        for (int k = 1; k <= acc; k++) begin
            chk($sformatf("w%0d_acc%0d_en", w, k), apb_if.apb_en, 1);
            chk($sformatf("w%0d_acc%0d_addr", w, k), apb_if.apb_addr, exp_addr[w]);
            chk($sformatf("w%0d_acc%0d_data", w, k), apb_if.apb_wdata, exp_data[w]);
            if (k == acc) apb_if.apb_ready = 1'b1;
            step();
        end
    endtask

    task automatic wait_pre_rst(input string tag);
        n = 0;
        while (pll_rst && !apb_if.apb_sel && n < 100) begin
            n++;
            step();
        end
        chk(tag, n, 16);
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        n = 0;
        while (!cfg_done && n < 200) begin
            step();
            n++;
        end
        chk(tag, n, exp_n);
        chk({tag, "_errcode"}, err_code, 2'b00);
        chk({tag, "_busy"}, cfg_busy, 0);
        chk({tag, "_err"}, cfg_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_start = 1'b0; pll_lock = 1'b0;
        cfg_addr = ADDR_VEC; cfg_data = DATA_VEC;
        apb_if.apb_ready = 1'b1;
        repeat (3) step();
        chk("rst_outs", {pll_rst, apb_if.apb_sel, apb_if.apb_en, apb_if.apb_write,
                         cfg_busy, cfg_done, cfg_err, lock_lost, apb_if.apb_rst_n, locked}, 0);
        chk("rst_bus", {apb_if.apb_addr, apb_if.apb_wdata, err_code}, 0);
        rst = 1'b0;
        step();
        chk("apb_rst_n_rel", apb_if.apb_rst_n, 1);

        // Nominal run, inputs scrambled after capture, lock back 10 cycles after release.
        pll_lock = 1'b1;
        repeat (3) step();
        chk("locked_up", locked, 1);
        start_run();
        pll_lock = 1'b0;
        chk("t1_busy", cfg_busy, 1);
        chk("t1_pllrst", pll_rst, 1);
        cfg_addr = 20'hFFFFF; cfg_data = 64'hDEAD_BEEF_DEAD_BEEF;
        wait_pre_rst("t1_pre_len");
        for (int w = 0; w < 4; w++) write_pair(w, 1);
        chk("t1_rel_pllrst", pll_rst, 0);
        chk("t1_rel_sel", apb_if.apb_sel, 0);
        chk("t1_rel_busy", cfg_busy, 1);
        repeat (10) step();
        pll_lock = 1'b1;
        wait_done("t1_done", 3);
        step();
        chk("t1_done_pulse", cfg_done, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // Three wait states on write 2.
        cfg_addr = ADDR_VEC; cfg_data = DATA_VEC;
        start_run();
        pll_lock = 1'b0;
        wait_pre_rst("t2_pre_len");
        for (int w = 0; w < 4; w++) write_pair(w, (w == 2) ? 4 : 1);
        chk("t2_rel_pllrst", pll_rst, 0);
        pll_lock = 1'b1;
        wait_done("t2_done", 3);

        // APB timeout.
        apb_if.apb_ready = 1'b0;
        start_run();
        wait_pre_rst("t3_pre_len");
        step();
        n = 0;
        while (apb_if.apb_en && n < 50) begin
            n++;
            step();
        end
        chk("t3_access_len", n, 8);
        chk("t3_err", cfg_err, 1);
        chk("t3_errcode", err_code, 2'b01);
        chk("t3_idle", {pll_rst, cfg_busy, apb_if.apb_sel, apb_if.apb_en, cfg_done}, 0);
        step();
        chk("t3_err_pulse", cfg_err, 0);
        chk("t3_errcode_hold", err_code, 2'b01);
        apb_if.apb_ready = 1'b1;

        // Lock timeout.
        start_run();
        chk("t4_errcode_clr", err_code, 2'b00);
        pll_lock = 1'b0;
        n = 0;
        while (pll_rst && n < 200) begin
            step();
            n++;
        end
        chk("t4_rel_busy", cfg_busy, 1);
        step();
        n = 0;
        while (!cfg_err && n < 300) begin
            step();
            n++;
        end
        chk("t4_lock_tmo", n, 100);
        chk("t4_errcode", err_code, 2'b10);
        chk("t4_busy", cfg_busy, 0);
        chk("t4_done", cfg_done, 0);

        // Start while busy is ignored.
        start_run();
        wait_pre_rst("t5_pre_len");
        step();
        cfg_start = 1'b1;
        cfg_addr = 20'h0;
        step();
        cfg_start = 1'b0;
        chk("t5_next_addr", apb_if.apb_addr, exp_addr[1]);
        n = 0;
        while (pll_rst && n < 200) begin
            step();
            n++;
        end
        pll_lock = 1'b1;
        wait_done("t5_done", 3);
        step();
        chk("t5_no_restart", cfg_busy, 0);

        // Reset in PRE_RST of a new run.
        d0 = done_cnt; e0 = err_cnt;
        start_run();
        repeat (4) step();
        chk("t5_in_pre", pll_rst, 1);
        rst = 1'b1;
        step();
        chk("t5_rst_outs", {pll_rst, apb_if.apb_sel, apb_if.apb_en, apb_if.apb_write,
                            cfg_busy, cfg_done, cfg_err, lock_lost, apb_if.apb_rst_n, locked}, 0);
        chk("t5_rst_bus", {apb_if.apb_addr, apb_if.apb_wdata, err_code}, 0);
        step();
        rst = 1'b0;
        step();
        chk("t5_apb_rst_n", apb_if.apb_rst_n, 1);
        step();
        chk("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        chk("t5_idle", cfg_busy, 0);

        // Lock loss while idle.
        repeat (4) step();
        chk("t6_locked", locked, 1);
        chk("t6_ll_none_busy", ll_cnt, 0);
        pll_lock = 1'b0;
        step();
        chk("t6_c1_ll", lock_lost, 0);
        chk("t6_c1_locked", locked, 1);
        step();
        chk("t6_c2_ll", lock_lost, 0);
        chk("t6_c2_locked", locked, 0);
        step();
        chk("t6_c3_ll", lock_lost, 1);
        step();
        chk("t6_c4_ll", lock_lost, 0);
        repeat (3) step();
        chk("t6_ll_cnt", ll_cnt, 1);
        chk("proto", proto_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
